// File: rtl/cmd_arb.sv
// Round-robin arbiter sharing one command executor between N_REQ sources.
// One command outstanding at a time; a watchdog forces an error response if the executor goes silent.
module cmd_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 1023,
    parameter logic [31:0] TO_CODE = 32'hDEAD_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [32*N_REQ-1:0]    req_cmd,
    output logic [N_REQ-1:0]       req_ack,
    output logic [N_REQ-1:0]       req_rsp_valid,
    output logic                   req_rsp_err,
    output logic [31:0]            req_rsp_data,
    output logic [31:0]            exe_cmd_data,
    output logic                   exe_cmd_waitreq,
    input  logic                   exe_cmd_rdreq,
    input  logic [31:0]            exe_rsp_data,
    input  logic                   exe_rsp_wrreq,
    output logic                   exe_rsp_waitreq,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic [7:0]             to_count
);
    localparam int unsigned DW  = 32;
    localparam int unsigned IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WDW = 16;
    localparam int unsigned CW  = 8;
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [IW-1:0]  PTR_RST  = IW'(N_REQ - 1);
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OFFER,
        S_WAIT_RSP,
        S_DELIVER
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [WDW-1:0]  wd_q, wd_d;

    logic [DW-1:0]   cmd_d;
    logic [2:0]      gid_d;
    logic [N_REQ-1:0] ack_d;
    logic [N_REQ-1:0] rspv_d;
    logic            err_d;
    logic [DW-1:0]   rdata_d;
    logic [CW-1:0]   toc_d;

    logic [IW-1:0]   win;
    logic            win_found;
    logic [DW-1:0]   win_cmd;

    // First pending requester after the last grant, wrapping around.
    always_comb begin
        win       = ptr_q;
        win_found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            if (!win_found && req_valid[IW'((32'(ptr_q) + k) % N_REQ)]) begin
                win_found = 1'b1;
                win       = IW'((32'(ptr_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        win_cmd = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (IW'(i) == win) begin
                win_cmd = req_cmd[DW*i +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = exe_cmd_data;
        gid_d   = grant_id;
        ptr_d   = ptr_q;
        ack_d   = '0;
        rspv_d  = '0;
        err_d   = 1'b0;
        rdata_d = req_rsp_data;
        wd_d    = wd_q;
        toc_d   = to_count;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d    = S_OFFER;
                    cmd_d      = win_cmd;
                    gid_d      = 3'(win);
                    ptr_d      = win;
                    ack_d[win] = 1'b1;
                end
            end
            S_OFFER: begin
                if (exe_cmd_rdreq) begin
                    state_d = S_WAIT_RSP;
                    wd_d    = '0;
                end
            end
            S_WAIT_RSP: begin
                // A real response beats a watchdog expiry in the same cycle.
                if (exe_rsp_wrreq) begin
                    state_d       = S_DELIVER;
                    rdata_d       = exe_rsp_data;
                    rspv_d[ptr_q] = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    state_d       = S_DELIVER;
                    rdata_d       = TO_CODE | DW'(grant_id);
                    err_d         = 1'b1;
                    rspv_d[ptr_q] = 1'b1;
                    if (to_count != CNT_MAX) begin
                        toc_d = to_count + CW'(1);
                    end
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_DELIVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs are loaded from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q           <= PTR_RST;
            wd_q            <= '0;
            exe_cmd_data    <= '0;
            grant_id        <= '0;
            req_ack         <= '0;
            req_rsp_valid   <= '0;
            req_rsp_err     <= 1'b0;
            req_rsp_data    <= '0;
            to_count        <= '0;
            exe_cmd_waitreq <= 1'b1;
            exe_rsp_waitreq <= 1'b1;
            busy            <= 1'b0;
        end else begin
            ptr_q           <= ptr_d;
            wd_q            <= wd_d;
            exe_cmd_data    <= cmd_d;
            grant_id        <= gid_d;
            req_ack         <= ack_d;
            req_rsp_valid   <= rspv_d;
            req_rsp_err     <= err_d;
            req_rsp_data    <= rdata_d;
            to_count        <= toc_d;
            exe_cmd_waitreq <= (state_d != S_OFFER);
            exe_rsp_waitreq <= (state_d != S_WAIT_RSP);
            busy            <= (state_d != S_IDLE);
        end
    end

endmodule
